// File: rtl/dpram_port_arbiter_pkg.sv
// dpram_port_arbiter_pkg: shared state encoding, RAM geometry and burst helper
// for the two-requester block-RAM port arbiter.
package dpram_port_arbiter_pkg;

  localparam int RAM_DEPTH     = 1024;
  localparam int RAM_ADDR_W    = $clog2(RAM_DEPTH);
  localparam int RAM_DATA_W    = 16;
  localparam int MAX_BURST_DEF = 4;
  localparam int BURST_CNT_W   = 4;

  // State records which requester won the previous cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Saturating increment used by the locked-burst counter.
  function automatic logic [BURST_CNT_W-1:0] burst_sat_inc(
    input logic [BURST_CNT_W-1:0] cnt,
    input logic [BURST_CNT_W-1:0] cap
  );
    logic [BURST_CNT_W-1:0] nxt;
    if (cnt >= cap) begin
      nxt = cap;
    end else begin
      nxt = cnt + BURST_CNT_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dpram_arb_rr_pick.sv
// dpram_arb_rr_pick: combinational winner selection for the port arbiter.
// Round-robin between two requesters, with a locked owner allowed to keep
// the port while its burst count is below the cap.
module dpram_arb_rr_pick
  import dpram_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   lock0,
  input  logic                   lock1,
  input  arb_state_e             state,
  input  logic [BURST_CNT_W-1:0] burst_cnt,
  input  logic                   last_gnt,
  output logic                   pick0,
  output logic                   pick1
);

  localparam logic [BURST_CNT_W-1:0] BURST_CAP = BURST_CNT_W'(MAX_BURST);

  logic hold0_s;
  logic hold1_s;

  // Decide whether the current owner may keep the port, then pick the winner.
  always_comb begin
    hold0_s = 1'b0;
    hold1_s = 1'b0;
    pick0   = 1'b0;
    pick1   = 1'b0;
    case (state)
      OWN0:    hold0_s = lock0 && (burst_cnt < BURST_CAP);
      OWN1:    hold1_s = lock1 && (burst_cnt < BURST_CAP);
      IDLE:    begin
        hold0_s = 1'b0;
        hold1_s = 1'b0;
      end
      default: begin
        hold0_s = 1'b0;
        hold1_s = 1'b0;
      end
    endcase
    case ({req0, req1})
      2'b10: pick0 = 1'b1;
      2'b01: pick1 = 1'b1;
      2'b11: begin
        if (hold0_s) begin
          pick0 = 1'b1;
        end else if (hold1_s) begin
          pick1 = 1'b1;
        end else if (last_gnt) begin
          pick0 = 1'b1;
        end else begin
          pick1 = 1'b1;
        end
      end
      default: begin
        pick0 = 1'b0;
        pick1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: shares one port of the 1,024 x 16 dual-port block RAM
// between two requesters. Grants are combinational, read data returns one
// cycle after the grant alongside the RAM's registered output.
// Optional build macro DPRAM_ARB_STATS_EN adds wrapping grant/conflict counters.
module dpram_port_arbiter
  import dpram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef DPRAM_ARB_STATS_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [15:0]       conflict_cnt
`endif
);

  arb_state_e             state_r;
  logic                   last_gnt_r;
  logic [BURST_CNT_W-1:0] burst_cnt_r;
  logic                   rvalid0_r;
  logic                   rvalid1_r;

  logic req0_s;
  logic req1_s;
  logic pick0_s;
  logic pick1_s;
  logic same_owner_s;
  logic win_lock_s;

  localparam logic [BURST_CNT_W-1:0] BURST_CAP = BURST_CNT_W'(MAX_BURST);

  // Requests are ignored while reset is held so nothing is granted or written.
  assign req0_s = req0 & rst_n;
  assign req1_s = req1 & rst_n;

  dpram_arb_rr_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .req0      (req0_s),
    .req1      (req1_s),
    .lock0     (lock0),
    .lock1     (lock1),
    .state     (state_r),
    .burst_cnt (burst_cnt_r),
    .last_gnt  (last_gnt_r),
    .pick0     (pick0_s),
    .pick1     (pick1_s)
  );

  assign gnt0    = pick0_s;
  assign gnt1    = pick1_s;
  assign rvalid0 = rvalid0_r;
  assign rvalid1 = rvalid1_r;
  assign rdata0  = ram_rdata;
  assign rdata1  = ram_rdata;

  // Steer the winner's address, data and write strobe onto the RAM port.
  always_comb begin
    ram_en    = 1'b0;
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = {DATA_W{1'b0}};
    if (pick0_s) begin
      ram_en    = we0;
      ram_addr  = addr0;
      ram_wdata = wdata0;
    end else if (pick1_s) begin
      ram_en    = we1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
    end else begin
      ram_en    = 1'b0;
      ram_addr  = {ADDR_W{1'b0}};
      ram_wdata = {DATA_W{1'b0}};
    end
  end

  // A burst continues only when the same requester wins again with lock held.
  always_comb begin
    same_owner_s = 1'b0;
    win_lock_s   = 1'b0;
    if (pick0_s) begin
      same_owner_s = (state_r == OWN0);
      win_lock_s   = lock0;
    end else if (pick1_s) begin
      same_owner_s = (state_r == OWN1);
      win_lock_s   = lock1;
    end else begin
      same_owner_s = 1'b0;
      win_lock_s   = 1'b0;
    end
  end

  // Owner FSM, round-robin history, burst counter and read-valid pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      last_gnt_r  <= 1'b1;
      burst_cnt_r <= {BURST_CNT_W{1'b0}};
      rvalid0_r   <= 1'b0;
      rvalid1_r   <= 1'b0;
    end else begin
      rvalid0_r <= pick0_s & ~we0;
      rvalid1_r <= pick1_s & ~we1;
      if (pick0_s || pick1_s) begin
        state_r    <= pick0_s ? OWN0 : OWN1;
        last_gnt_r <= pick1_s;
        if (same_owner_s && win_lock_s) begin
          burst_cnt_r <= burst_sat_inc(burst_cnt_r, BURST_CAP);
        end else begin
          burst_cnt_r <= BURST_CNT_W'(1);
        end
      end else begin
        state_r     <= IDLE;
        last_gnt_r  <= last_gnt_r;
        burst_cnt_r <= {BURST_CNT_W{1'b0}};
      end
    end
  end

`ifdef DPRAM_ARB_STATS_EN
  logic [15:0] gnt_cnt0_r;
  logic [15:0] gnt_cnt1_r;
  logic [15:0] conflict_cnt_r;

  // Wrapping counts of grants per requester and of contended cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_r     <= 16'd0;
      gnt_cnt1_r     <= 16'd0;
      conflict_cnt_r <= 16'd0;
    end else begin
      if (pick0_s) begin
        gnt_cnt0_r <= gnt_cnt0_r + 16'd1;
      end else begin
        gnt_cnt0_r <= gnt_cnt0_r;
      end
      if (pick1_s) begin
        gnt_cnt1_r <= gnt_cnt1_r + 16'd1;
      end else begin
        gnt_cnt1_r <= gnt_cnt1_r;
      end
      if (req0_s && req1_s) begin
        conflict_cnt_r <= conflict_cnt_r + 16'd1;
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
    end
  end

  assign gnt_cnt0     = gnt_cnt0_r;
  assign gnt_cnt1     = gnt_cnt1_r;
  assign conflict_cnt = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: self-checking bench for dpram_port_arbiter with a
// registered-output RAM model and a read-data scoreboard.
module tb_dpram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic        lock0 = 1'b0, lock1 = 1'b0;
  logic [9:0]  addr0 = 10'h0, addr1 = 10'h0;
  logic [15:0] wdata0 = 16'h0, wdata1 = 16'h0;
  logic        gnt0, gnt1, rvalid0, rvalid1, ram_en;
  logic [15:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [9:0]  ram_addr;
`ifdef DPRAM_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [15:0] d;
  } rv_t;

  typedef struct {
    logic r0, w0, l0; logic [9:0] a0; logic [15:0] d0;
    logic r1, w1, l1; logic [9:0] a1; logic [15:0] d1;
    logic [1:0] g;   // expected {gnt0, gnt1}
  } vec_t;

  rv_t sb_q[$];

  // RAM model state and the bench's own view of what has been written
  logic [15:0] ram_mem [1024];
  bit          ram_wr  [1024];
  logic [15:0] sh_mem  [1024];
  bit          sh_wr   [1024];

  always #5 clk = ~clk;

  dpram_port_arbiter #(
    .ADDR_W(10), .DATA_W(16), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef DPRAM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt)
`endif
  );

  function automatic logic [15:0] pat(input logic [9:0] a);
    return {a[5:0], a} ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] rd_exp(input logic [9:0] a);
    return sh_wr[a] ? sh_mem[a] : pat(a);
  endfunction

  function automatic vec_t mk(input logic r0, w0, l0, input logic [9:0] a0, input logic [15:0] d0,
                              input logic r1, w1, l1, input logic [9:0] a1, input logic [15:0] d1,
                              input logic [1:0] g);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g  = g;
    return v;
  endfunction

  // Synchronous RAM: write on ram_en, registered read-first output
  always @(posedge clk) begin
    ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : pat(ram_addr);
    if (ram_en) begin
      ram_mem[ram_addr] <= ram_wdata;
      ram_wr[ram_addr]  <= 1'b1;
    end
  end

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb_q.delete();
    sb_q.push_back('{1'b0, 1'b0, 16'h0});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 10'h011; wdata0 = 16'h1234;
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1, ram_en} !== 3'b000) begin
      n_err++; $display("FAIL reset_gnt got %b want 000", {gnt0, gnt1, ram_en});
    end
    n_vec++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      n_err++; $display("FAIL reset_rvalid got %b want 00", {rvalid0, rvalid1});
    end
    do_reset();
  endtask

  task automatic test_lone_read();
    vec_t v[$]; rv_t sb; logic [9:0] ea; logic ee; logic [15:0] ed;
    do_reset();
    v.push_back(mk(1, 0, 0, 10'h005, 16'h0, 0, 0, 0, 10'h000, 16'h0, 2'b10));
    v.push_back(mk(0, 0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0, 2'b00));
    foreach (v[i]) begin
      req0 = v[i].r0; we0 = v[i].w0; lock0 = v[i].l0; addr0 = v[i].a0; wdata0 = v[i].d0;
      req1 = v[i].r1; we1 = v[i].w1; lock1 = v[i].l1; addr1 = v[i].a1; wdata1 = v[i].d1;
      @(negedge clk);
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL lone_sb empty at cycle %0d", i);
      end else begin
        sb = sb_q.pop_front();
        if ({rvalid0, rvalid1} !== {sb.v0, sb.v1}) begin
          n_err++; $display("FAIL lone_rvalid cyc %0d got %b want %b", i, {rvalid0, rvalid1}, {sb.v0, sb.v1});
        end
        if (sb.v0 || sb.v1) begin
          n_vec++;
          if ((sb.v0 ? rdata0 : rdata1) !== sb.d) begin
            n_err++; $display("FAIL lone_rdata cyc %0d got %h want %h", i, sb.v0 ? rdata0 : rdata1, sb.d);
          end
        end
      end
      n_vec++;
      if ({gnt0, gnt1} !== v[i].g) begin
        n_err++; $display("FAIL lone_gnt cyc %0d got %b want %b", i, {gnt0, gnt1}, v[i].g);
      end
      ea = v[i].g[1] ? v[i].a0 : (v[i].g[0] ? v[i].a1 : 10'h000);
      ee = v[i].g[1] ? v[i].w0 : (v[i].g[0] ? v[i].w1 : 1'b0);
      ed = v[i].g[1] ? v[i].d0 : (v[i].g[0] ? v[i].d1 : 16'h0);
      n_vec++;
      if ({ram_en, ram_addr, ram_wdata} !== {ee, ea, ed}) begin
        n_err++; $display("FAIL lone_ram cyc %0d got %b/%h/%h want %b/%h/%h", i, ram_en, ram_addr, ram_wdata, ee, ea, ed);
      end
      if (v[i].g == 2'b10 && !v[i].w0) sb_q.push_back('{1'b1, 1'b0, rd_exp(v[i].a0)});
      else if (v[i].g == 2'b01 && !v[i].w1) sb_q.push_back('{1'b0, 1'b1, rd_exp(v[i].a1)});
      else sb_q.push_back('{1'b0, 1'b0, 16'h0});
      if (ee) begin sh_wr[ea] = 1'b1; sh_mem[ea] = ed; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    vec_t v[$]; rv_t sb; logic [9:0] ea; logic ee; logic [15:0] ed;
    do_reset();
    for (int k = 0; k < 6; k++)
      v.push_back(mk(1, 0, 0, 10'h010, 16'h0, 1, 0, 0, 10'h200, 16'h0, (k % 2 == 0) ? 2'b10 : 2'b01));
    v.push_back(mk(0, 0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0, 2'b00));
    foreach (v[i]) begin
      req0 = v[i].r0; we0 = v[i].w0; lock0 = v[i].l0; addr0 = v[i].a0; wdata0 = v[i].d0;
      req1 = v[i].r1; we1 = v[i].w1; lock1 = v[i].l1; addr1 = v[i].a1; wdata1 = v[i].d1;
      @(negedge clk);
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL cont_sb empty at cycle %0d", i);
      end else begin
        sb = sb_q.pop_front();
        if ({rvalid0, rvalid1} !== {sb.v0, sb.v1}) begin
          n_err++; $display("FAIL cont_rvalid cyc %0d got %b want %b", i, {rvalid0, rvalid1}, {sb.v0, sb.v1});
        end
        if (sb.v0 || sb.v1) begin
          n_vec++;
          if ((sb.v0 ? rdata0 : rdata1) !== sb.d) begin
            n_err++; $display("FAIL cont_rdata cyc %0d got %h want %h", i, sb.v0 ? rdata0 : rdata1, sb.d);
          end
        end
      end
      n_vec++;
      if ({gnt0, gnt1} !== v[i].g) begin
        n_err++; $display("FAIL cont_gnt cyc %0d got %b want %b", i, {gnt0, gnt1}, v[i].g);
      end
      ea = v[i].g[1] ? v[i].a0 : (v[i].g[0] ? v[i].a1 : 10'h000);
      ee = v[i].g[1] ? v[i].w0 : (v[i].g[0] ? v[i].w1 : 1'b0);
      ed = v[i].g[1] ? v[i].d0 : (v[i].g[0] ? v[i].d1 : 16'h0);
      n_vec++;
      if ({ram_en, ram_addr, ram_wdata} !== {ee, ea, ed}) begin
        n_err++; $display("FAIL cont_ram cyc %0d got %b/%h/%h want %b/%h/%h", i, ram_en, ram_addr, ram_wdata, ee, ea, ed);
      end
      if (v[i].g == 2'b10 && !v[i].w0) sb_q.push_back('{1'b1, 1'b0, rd_exp(v[i].a0)});
      else if (v[i].g == 2'b01 && !v[i].w1) sb_q.push_back('{1'b0, 1'b1, rd_exp(v[i].a1)});
      else sb_q.push_back('{1'b0, 1'b0, 16'h0});
      if (ee) begin sh_wr[ea] = 1'b1; sh_mem[ea] = ed; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst();
    vec_t v[$]; rv_t sb; logic [9:0] ea; logic ee; logic [15:0] ed;
    logic [1:0] seq [8];
    seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
    do_reset();
    for (int k = 0; k < 8; k++)
      v.push_back(mk(1, 0, 1, 10'h030, 16'h0, 1, 0, 0, 10'h300, 16'h0, seq[k]));
    v.push_back(mk(0, 0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0, 2'b00));
    // owner alone long enough that an unsaturated 4-bit counter would wrap
    for (int k = 0; k < 16; k++)
      v.push_back(mk(1, 0, 1, 10'h031, 16'h0, 0, 0, 0, 10'h000, 16'h0, 2'b10));
    v.push_back(mk(1, 0, 1, 10'h031, 16'h0, 1, 0, 0, 10'h301, 16'h0, 2'b01));
    v.push_back(mk(0, 0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0, 2'b00));
    foreach (v[i]) begin
      req0 = v[i].r0; we0 = v[i].w0; lock0 = v[i].l0; addr0 = v[i].a0; wdata0 = v[i].d0;
      req1 = v[i].r1; we1 = v[i].w1; lock1 = v[i].l1; addr1 = v[i].a1; wdata1 = v[i].d1;
      @(negedge clk);
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL burst_sb empty at cycle %0d", i);
      end else begin
        sb = sb_q.pop_front();
        if ({rvalid0, rvalid1} !== {sb.v0, sb.v1}) begin
          n_err++; $display("FAIL burst_rvalid cyc %0d got %b want %b", i, {rvalid0, rvalid1}, {sb.v0, sb.v1});
        end
        if (sb.v0 || sb.v1) begin
          n_vec++;
          if ((sb.v0 ? rdata0 : rdata1) !== sb.d) begin
            n_err++; $display("FAIL burst_rdata cyc %0d got %h want %h", i, sb.v0 ? rdata0 : rdata1, sb.d);
          end
        end
      end
      n_vec++;
      if ({gnt0, gnt1} !== v[i].g) begin
        n_err++; $display("FAIL burst_gnt cyc %0d got %b want %b", i, {gnt0, gnt1}, v[i].g);
      end
      ea = v[i].g[1] ? v[i].a0 : (v[i].g[0] ? v[i].a1 : 10'h000);
      ee = v[i].g[1] ? v[i].w0 : (v[i].g[0] ? v[i].w1 : 1'b0);
      ed = v[i].g[1] ? v[i].d0 : (v[i].g[0] ? v[i].d1 : 16'h0);
      n_vec++;
      if ({ram_en, ram_addr, ram_wdata} !== {ee, ea, ed}) begin
        n_err++; $display("FAIL burst_ram cyc %0d got %b/%h/%h want %b/%h/%h", i, ram_en, ram_addr, ram_wdata, ee, ea, ed);
      end
      if (v[i].g == 2'b10 && !v[i].w0) sb_q.push_back('{1'b1, 1'b0, rd_exp(v[i].a0)});
      else if (v[i].g == 2'b01 && !v[i].w1) sb_q.push_back('{1'b0, 1'b1, rd_exp(v[i].a1)});
      else sb_q.push_back('{1'b0, 1'b0, 16'h0});
      if (ee) begin sh_wr[ea] = 1'b1; sh_mem[ea] = ed; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_read();
    vec_t v[$]; rv_t sb; logic [9:0] ea; logic ee; logic [15:0] ed;
    do_reset();
    v.push_back(mk(0, 0, 0, 10'h000, 16'h0, 1, 1, 0, 10'h3FF, 16'hBEEF, 2'b01));
    v.push_back(mk(0, 0, 0, 10'h000, 16'h0, 1, 0, 0, 10'h3FF, 16'h0, 2'b01));
    v.push_back(mk(0, 0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0, 2'b00));
    foreach (v[i]) begin
      req0 = v[i].r0; we0 = v[i].w0; lock0 = v[i].l0; addr0 = v[i].a0; wdata0 = v[i].d0;
      req1 = v[i].r1; we1 = v[i].w1; lock1 = v[i].l1; addr1 = v[i].a1; wdata1 = v[i].d1;
      @(negedge clk);
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL wr_sb empty at cycle %0d", i);
      end else begin
        sb = sb_q.pop_front();
        if ({rvalid0, rvalid1} !== {sb.v0, sb.v1}) begin
          n_err++; $display("FAIL wr_rvalid cyc %0d got %b want %b", i, {rvalid0, rvalid1}, {sb.v0, sb.v1});
        end
        if (sb.v0 || sb.v1) begin
          n_vec++;
          if ((sb.v0 ? rdata0 : rdata1) !== sb.d) begin
            n_err++; $display("FAIL wr_rdata cyc %0d got %h want %h", i, sb.v0 ? rdata0 : rdata1, sb.d);
          end
        end
      end
      n_vec++;
      if ({gnt0, gnt1} !== v[i].g) begin
        n_err++; $display("FAIL wr_gnt cyc %0d got %b want %b", i, {gnt0, gnt1}, v[i].g);
      end
      ea = v[i].g[1] ? v[i].a0 : (v[i].g[0] ? v[i].a1 : 10'h000);
      ee = v[i].g[1] ? v[i].w0 : (v[i].g[0] ? v[i].w1 : 1'b0);
      ed = v[i].g[1] ? v[i].d0 : (v[i].g[0] ? v[i].d1 : 16'h0);
      n_vec++;
      if ({ram_en, ram_addr, ram_wdata} !== {ee, ea, ed}) begin
        n_err++; $display("FAIL wr_ram cyc %0d got %b/%h/%h want %b/%h/%h", i, ram_en, ram_addr, ram_wdata, ee, ea, ed);
      end
      if (v[i].g == 2'b10 && !v[i].w0) sb_q.push_back('{1'b1, 1'b0, rd_exp(v[i].a0)});
      else if (v[i].g == 2'b01 && !v[i].w1) sb_q.push_back('{1'b0, 1'b1, rd_exp(v[i].a1)});
      else sb_q.push_back('{1'b0, 1'b0, 16'h0});
      if (ee) begin sh_wr[ea] = 1'b1; sh_mem[ea] = ed; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h0AB;
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_err++; $display("FAIL rstmid_first_gnt got %b want 10", {gnt0, gnt1});
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    n_vec++;
    if (rvalid0 !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre_rvalid got %b want 1", rvalid0);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_drop_rvalid got %b want 00", {rvalid0, rvalid1});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 10'h0AB; addr1 = 10'h0CD;
    @(negedge clk);
    n_vec++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_post_rvalid got %b want 00", {rvalid0, rvalid1});
    end
    n_vec++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_err++; $display("FAIL rstmid_post_gnt got %b want 10", {gnt0, gnt1});
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({rvalid0, rdata0} !== {1'b1, rd_exp(10'h0AB)}) begin
      n_err++; $display("FAIL rstmid_reissue got %b/%h want 1/%h", rvalid0, rdata0, rd_exp(10'h0AB));
    end
  endtask

`ifdef DPRAM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    n_vec++;
    if ({gnt_cnt0, gnt_cnt1, conflict_cnt} !== 48'h0) begin
      n_err++; $display("FAIL stats_reset got %h/%h/%h want 0/0/0", gnt_cnt0, gnt_cnt1, conflict_cnt);
    end
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = 10'h040; addr1 = 10'h140;
    repeat (10) @(posedge clk);
    #1 req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (conflict_cnt !== 16'd10) begin
      n_err++; $display("FAIL stats_conflict got %0d want 10", conflict_cnt);
    end
    n_vec++;
    if ({gnt_cnt0, gnt_cnt1} !== {16'd5, 16'd5}) begin
      n_err++; $display("FAIL stats_gnt got %0d/%0d want 5/5", gnt_cnt0, gnt_cnt1);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lone_read();
    test_contention();
    test_burst();
    test_write_read();
    test_reset_mid_read();
`ifdef DPRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
